// File: rtl/item_table_ctrl.sv
// Item table for the vending machine: per-slot price/stock in a sync-read RAM
// plus a valid bit per slot, driven by atomic WRITE/READ/VEND/RESTOCK commands.
module item_table_ctrl #(
  parameter int MAX_ITEMS = 1024,
  parameter int PRICE_W   = 16,
  parameter int COUNT_W   = 8,
  localparam int AW       = $clog2(MAX_ITEMS)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [1:0]         cmd_op_i,
  input  logic [AW-1:0]      cmd_addr_i,
  input  logic [PRICE_W-1:0] cmd_price_i,
  input  logic [COUNT_W-1:0] cmd_count_i,
  output logic               rsp_valid_o,
  output logic [1:0]         rsp_status_o,
  output logic [PRICE_W-1:0] rsp_price_o,
  output logic [COUNT_W-1:0] rsp_count_o
);

  typedef enum logic [1:0] {OP_WRITE, OP_READ, OP_VEND, OP_RESTOCK} op_e;
  typedef enum logic [1:0] {ST_OK, ST_EMPTY, ST_INVALID, ST_SATURATED} status_e;
  typedef enum logic {IDLE, EXEC} state_e;

  localparam int DW = PRICE_W + COUNT_W;
  localparam logic [AW:0] MAX_L = MAX_ITEMS[AW:0];

  logic [DW-1:0]        mem_q [MAX_ITEMS];
  logic [MAX_ITEMS-1:0] valid_q;
  state_e               state_q, state_d;

  logic [1:0]           op_q;
  logic [AW-1:0]        addr_q;
  logic [COUNT_W-1:0]   qty_q;
  logic                 hit_q;
  logic [DW-1:0]        rd_q;

  logic                 rsp_valid_q;
  logic [1:0]           rsp_status_q;
  logic [PRICE_W-1:0]   rsp_price_q;
  logic [COUNT_W-1:0]   rsp_count_q;

  logic                 accept, in_range, is_write;
  logic [PRICE_W-1:0]   rd_price;
  logic [COUNT_W-1:0]   rd_count;
  logic [COUNT_W:0]     sum;
  logic [1:0]           ex_status;
  logic [PRICE_W-1:0]   ex_price;
  logic [COUNT_W-1:0]   ex_count;
  logic                 ex_we;
  logic                 we;
  logic [AW-1:0]        waddr;
  logic [DW-1:0]        wdata;

  assign cmd_ready_o = (state_q == IDLE) && !rst_i;
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign in_range    = ({1'b0, cmd_addr_i} < MAX_L);
  assign is_write    = (cmd_op_i == OP_WRITE);
  assign rd_price    = rd_q[PRICE_W-1:0];
  assign rd_count    = rd_q[DW-1:PRICE_W];
  assign sum         = {1'b0, rd_count} + {1'b0, qty_q};

  // Result of the latched op against the RAM word fetched at accept time.
  always_comb begin
    ex_status = ST_OK;
    ex_price  = rd_price;
    ex_count  = rd_count;
    ex_we     = 1'b0;
    case (op_q)
      OP_VEND: begin
        if (rd_count == '0) begin
          ex_status = ST_EMPTY;
        end else begin
          ex_count = rd_count - 1'b1;
          ex_we    = 1'b1;
        end
      end
      OP_RESTOCK: begin
        ex_we = 1'b1;
        if (sum[COUNT_W]) begin
          ex_status = ST_SATURATED;
          ex_count  = '1;
        end else begin
          ex_count = sum[COUNT_W-1:0];
        end
      end
      default: ;
    endcase
    if (!hit_q) begin
      ex_status = ST_INVALID;
      ex_price  = '0;
      ex_count  = '0;
      ex_we     = 1'b0;
    end
  end

  // Single write port: WRITE at accept or writeback at the EXEC edge never coincide.
  always_comb begin
    we    = 1'b0;
    waddr = cmd_addr_i;
    wdata = {cmd_count_i, cmd_price_i};
    if (accept && is_write && in_range) begin
      we = 1'b1;
    end else if (state_q == EXEC && ex_we && !rst_i) begin
      we    = 1'b1;
      waddr = addr_q;
      wdata = {ex_count, rd_price};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !is_write) state_d = EXEC;
      EXEC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (we) mem_q[waddr] <= wdata;
    if (accept && in_range) rd_q <= mem_q[cmd_addr_i];
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      op_q   <= cmd_op_i;
      addr_q <= cmd_addr_i;
      qty_q  <= cmd_count_i;
      hit_q  <= in_range && valid_q[cmd_addr_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= '0;
      rsp_price_q  <= '0;
      rsp_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= 1'b0;
      if (we) valid_q[waddr] <= 1'b1;
      if (accept && is_write) begin
        rsp_valid_q  <= 1'b1;
        rsp_status_q <= in_range ? ST_OK : ST_INVALID;
        rsp_price_q  <= in_range ? cmd_price_i : '0;
        rsp_count_q  <= in_range ? cmd_count_i : '0;
      end else if (state_q == EXEC) begin
        rsp_valid_q  <= 1'b1;
        rsp_status_q <= ex_status;
        rsp_price_q  <= ex_price;
        rsp_count_q  <= ex_count;
      end
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_status_o = rsp_status_q;
  assign rsp_price_o  = rsp_price_q;
  assign rsp_count_o  = rsp_count_q;

endmodule

// File: tb/tb_item_table_ctrl.sv
// Randomized + directed bench for item_table_ctrl: array-based reference model
// compared every cycle, plus literal expectations and a MAX_ITEMS=1000 instance.
module tb_item_table_ctrl;
  localparam int PW = 16, CW = 8, NA = 1024, NB = 1000;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, sel_b = 1'b0;
  logic [1:0]  cmd_op = '0;
  logic [9:0]  cmd_addr = '0;
  logic [15:0] cmd_price = '0;
  logic [7:0]  cmd_count = '0;
  logic cva, cvb;
  assign cva = cmd_valid & ~sel_b;
  assign cvb = cmd_valid & sel_b;

  logic rdy_a, rv_a, rdy_b, rv_b;
  logic [1:0] st_a, st_b;
  logic [15:0] pr_a, pr_b;
  logic [7:0] ct_a, ct_b;

  item_table_ctrl #(.MAX_ITEMS(NA), .PRICE_W(PW), .COUNT_W(CW)) dut_a (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cva), .cmd_ready_o(rdy_a),
    .cmd_op_i(cmd_op), .cmd_addr_i(cmd_addr), .cmd_price_i(cmd_price),
    .cmd_count_i(cmd_count), .rsp_valid_o(rv_a), .rsp_status_o(st_a),
    .rsp_price_o(pr_a), .rsp_count_o(ct_a));

  item_table_ctrl #(.MAX_ITEMS(NB), .PRICE_W(PW), .COUNT_W(CW)) dut_b (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cvb), .cmd_ready_o(rdy_b),
    .cmd_op_i(cmd_op), .cmd_addr_i(cmd_addr), .cmd_price_i(cmd_price),
    .cmd_count_i(cmd_count), .rsp_valid_o(rv_b), .rsp_status_o(st_b),
    .rsp_price_o(pr_b), .rsp_count_o(ct_b));

  always #5 clk = ~clk;

  int n_chk = 0, errors = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: slot arrays plus at most one pending multi-cycle op.
  bit mv [NA];
  int mp [NA], mc [NA];
  bit m_busy = 0, m_rv = 0;
  int p_op, p_addr, p_qty;
  int m_st = 0, m_pr = 0, m_ct = 0;

  always @(posedge clk) begin
    m_rv = 0;
    if (rst) begin
      for (int i = 0; i < NA; i++) mv[i] = 0;
      m_busy = 0; m_st = 0; m_pr = 0; m_ct = 0;
    end else if (m_busy) begin
      m_busy = 0;
      m_rv = 1;
      if (!mv[p_addr]) begin
        m_st = 2; m_pr = 0; m_ct = 0;
      end else begin
        m_st = 0; m_pr = mp[p_addr];
        if (p_op == 2) begin
          if (mc[p_addr] == 0) m_st = 1;
          else mc[p_addr] = mc[p_addr] - 1;
        end else if (p_op == 3) begin
          if (mc[p_addr] + p_qty > CMAX) begin
            mc[p_addr] = CMAX; m_st = 3;
          end else mc[p_addr] = mc[p_addr] + p_qty;
        end
        m_ct = mc[p_addr];
      end
    end else if (cva) begin
      if (cmd_op == 2'd0) begin
        mv[cmd_addr] = 1; mp[cmd_addr] = cmd_price; mc[cmd_addr] = cmd_count;
        m_rv = 1; m_st = 0; m_pr = cmd_price; m_ct = cmd_count;
      end else begin
        m_busy = 1; p_op = cmd_op; p_addr = cmd_addr; p_qty = cmd_count;
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("cmd_ready", 32'(rdy_a), 32'(!rst && !m_busy));
    chk("rsp_valid", 32'(rv_a), 32'(m_rv));
    chk("rsp_status", 32'(st_a), 32'(m_st));
    chk("rsp_price", 32'(pr_a), 32'(m_pr));
    chk("rsp_count", 32'(ct_a), 32'(m_ct));
  end

  logic [25:0] qa [$];
  logic [25:0] qb [$];
  always @(negedge clk) begin
    if (rv_a) qa.push_back({st_a, pr_a, ct_a});
    if (rv_b) qb.push_back({st_b, pr_b, ct_b});
  end

  task automatic send(input logic [1:0] op, input int a, input int p, input int c);
    bit ok = 0;
    cmd_valid = 1; cmd_op = op; cmd_addr = 10'(a); cmd_price = 16'(p); cmd_count = 8'(c);
    for (int k = 0; k < 8 && !ok; k++) begin
      @(negedge clk); ok = sel_b ? rdy_b : rdy_a;
      @(posedge clk); #1;
    end
    cmd_valid = 0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic expect_rsp(input string nm, input bit b, input int st, input int p, input int c);
    logic [25:0] r;
    int sz;
    for (int k = 0; k < 8; k++) begin
      sz = b ? qb.size() : qa.size();
      if (sz > 0) break;
      @(posedge clk); #1;
    end
    sz = b ? qb.size() : qa.size();
    if (sz == 0) begin
      chk({nm, "_timeout"}, 0, 1);
    end else begin
      r = b ? qb.pop_front() : qa.pop_front();
      chk({nm, "_status"}, 32'(r[25:24]), 32'(st));
      chk({nm, "_price"}, 32'(r[23:8]), 32'(p));
      chk({nm, "_count"}, 32'(r[7:0]), 32'(c));
    end
  endtask

  initial begin
    int acc, r;
    rst = 1;
    @(posedge clk); #1; chk_en = 1;
    @(negedge clk); chk("ready_in_rst", 32'(rdy_a), 0);
    @(posedge clk); #1; rst = 0;
    qa.delete(); qb.delete();

    send(2'd1, 5, 0, 0);                expect_rsp("rd_unwritten", 0, 2, 0, 0);
    send(2'd0, 5, 150, 2); send(2'd2, 5, 0, 0);
    expect_rsp("wr5", 0, 0, 150, 2);    expect_rsp("vend1", 0, 0, 150, 1);
    send(2'd2, 5, 0, 0);                expect_rsp("vend2", 0, 0, 150, 0);
    send(2'd2, 5, 0, 0);                expect_rsp("vend_empty", 0, 1, 150, 0);
    send(2'd1, 5, 0, 0);                expect_rsp("rd5", 0, 0, 150, 0);

    send(2'd0, 9, 20, 250);             expect_rsp("wr9", 0, 0, 20, 250);
    send(2'd3, 9, 0, 10);               expect_rsp("rs_sat", 0, 3, 20, 255);
    send(2'd3, 9, 0, 0);                expect_rsp("rs_zero", 0, 0, 20, 255);
    send(2'd0, 12, 30, 3); send(2'd3, 12, 0, 4);
    expect_rsp("wr12", 0, 0, 30, 3);    expect_rsp("rs_add", 0, 0, 30, 7);

    // Continuous VEND stream: only every second cycle may be accepted.
    send(2'd0, 20, 1, 200);             expect_rsp("wr20", 0, 0, 1, 200);
    qa.delete(); acc = 0;
    cmd_valid = 1; cmd_op = 2'd2; cmd_addr = 10'd20;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); if (rdy_a) acc++;
      @(posedge clk); #1;
    end
    cmd_valid = 0;
    repeat (4) begin @(posedge clk); #1; end
    chk("stream_accepts", 32'(acc), 10);
    chk("stream_rsps", 32'(qa.size()), 10);
    qa.delete();
    send(2'd1, 20, 0, 0);               expect_rsp("rd20", 0, 0, 1, 190);

    // Reset during EXEC drops the op.
    send(2'd0, 30, 9, 5);               expect_rsp("wr30", 0, 0, 9, 5);
    qa.delete();
    send(2'd2, 30, 0, 0);
    rst = 1; @(posedge clk); #1; @(posedge clk); #1; rst = 0;
    repeat (3) begin @(posedge clk); #1; end
    chk("no_rsp_after_rst", 32'(qa.size()), 0);
    send(2'd1, 30, 0, 0);               expect_rsp("rd30_inv", 0, 2, 0, 0);
    send(2'd0, 1023, 77, 4);            expect_rsp("wr1023", 0, 0, 77, 4);
    send(2'd1, 1023, 0, 0);             expect_rsp("rd1023", 0, 0, 77, 4);

    // Non power-of-two instance.
    sel_b = 1; qb.delete();
    send(2'd0, 1000, 11, 22);           expect_rsp("b_wr1000", 1, 2, 0, 0);
    send(2'd1, 1000, 0, 0);             expect_rsp("b_rd1000", 1, 2, 0, 0);
    send(2'd0, 999, 5, 6);              expect_rsp("b_wr999", 1, 0, 5, 6);
    send(2'd1, 999, 0, 0);              expect_rsp("b_rd999", 1, 0, 5, 6);
    sel_b = 0;

    // Random traffic; fields change every cycle whether or not accepted.
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_op = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 8);
      cmd_addr = (r == 8) ? 10'd1023 : 10'(r);
      cmd_price = 16'($urandom);
      cmd_count = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(245, 255)) : 8'($urandom_range(0, 6));
      @(posedge clk); #1;
    end
    rst = 0; cmd_valid = 0;
    repeat (4) begin @(posedge clk); #1; end
    $display("Result: errors=%0d of %0d checks", errors, n_chk);
    $finish;
  end

endmodule
